mem_ctrl: RTL and testbench

- Shares the single byte-wide RAM port between the IF stage (32-bit instruction fetch) and the MEM stage (byte/half/word load and store).
- Arbitrates between the two requesters and sequences each access as consecutive byte transactions, little-endian.
- Returns a one-cycle ready pulse to the requester when its access completes.
- Sits between the pipeline stages and the RAM.

---
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - pipeline request/response and byte-wide RAM port bundle for mem_ctrl
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_read;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_cancel;
  logic                  if_ready;
  logic [31:0]           if_data;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_len;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport slave (
    input  if_read, if_addr, if_cancel,
    input  mem_read, mem_write, mem_addr, mem_len, mem_wdata,
    input  ram_din,
    output if_ready, if_data, mem_ready, mem_rdata,
    output ram_addr, ram_wr, ram_dout
  );

  modport master (
    output if_read, if_addr, if_cancel,
    output mem_read, mem_write, mem_addr, mem_len, mem_wdata,
    output ram_din,
    input  if_ready, if_data, mem_ready, mem_rdata,
    input  ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port
// Each access is split into little-endian byte transactions; outputs are all registered.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mem_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            last_q, last_d;
  logic                  is_if_q, is_if_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  if_ready_q, if_ready_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  logic [1:0]            nxt;
  logic [31:0]           asm_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      is_if_q     <= 1'b0;
      asm_q       <= '0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_ready_q  <= 1'b0;
      if_data_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      is_if_q     <= is_if_d;
      asm_q       <= asm_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_ready_q  <= if_ready_d;
      if_data_q   <= if_data_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    is_if_d     = is_if_q;
    asm_d       = asm_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_ready_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;

    nxt      = cnt_q + 2'd1;
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = bus.ram_din;

    case (state_q)
      IDLE: begin
        // MEM outranks IF, and a store outranks a load
        if (bus.mem_write) begin
          state_d    = WRITE;
          base_d     = bus.mem_addr;
          last_d     = bus.mem_len;
          cnt_d      = 2'd0;
          is_if_d    = 1'b0;
          wdata_d    = bus.mem_wdata;
          ram_addr_d = bus.mem_addr;
          ram_wr_d   = 1'b1;
          ram_dout_d = bus.mem_wdata[7:0];
        end else if (bus.mem_read) begin
          state_d    = READ;
          base_d     = bus.mem_addr;
          last_d     = bus.mem_len;
          cnt_d      = 2'd0;
          is_if_d    = 1'b0;
          asm_d      = '0;
          ram_addr_d = bus.mem_addr;
        end else if (bus.if_read && !bus.if_cancel) begin
          state_d    = READ;
          base_d     = bus.if_addr;
          last_d     = 2'd3;
          cnt_d      = 2'd0;
          is_if_d    = 1'b1;
          asm_d      = '0;
          ram_addr_d = bus.if_addr;
        end
      end

      READ: begin
        // ram_din at this edge belongs to the address presented one cycle earlier
        if (is_if_q && bus.if_cancel) begin
          state_d = IDLE;
        end else if (cnt_q == last_q) begin
          state_d = DONE;
          asm_d   = asm_next;
          if (is_if_q) begin
            if_data_d  = asm_next;
            if_ready_d = 1'b1;
          end else begin
            mem_rdata_d = asm_next;
            mem_ready_d = 1'b1;
          end
        end else begin
          asm_d      = asm_next;
          cnt_d      = nxt;
          ram_addr_d = base_q + ADDR_WIDTH'(nxt);
        end
      end

      WRITE: begin
        if (cnt_q == last_q) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
        end else begin
          cnt_d      = nxt;
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + ADDR_WIDTH'(nxt);
          ram_dout_d = wdata_q[{nxt, 3'b000} +: 8];
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a byte RAM model and ready scoreboard
module tb_mem_ctrl;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(AW)) bus();
  mem_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0]  ram [0:65535];
  logic        pre_en;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;

  assign bus.ram_din = ram[bus.ram_addr[15:0]];

  always @(posedge clk) begin
    if (pre_en) ram[pre_a] <= pre_d;
    else if (bus.ram_wr) ram[bus.ram_addr[15:0]] <= bus.ram_dout;
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic        if_seen, mem_seen;
  logic [31:0] exp_v;

  task automatic tick();
    @(negedge clk);
    if_seen  = bus.if_ready;
    mem_seen = bus.mem_ready;
    if (reset && bus.if_ready) begin
      total++;
      if (if_q.size() == 0) begin
        bad++; $display("FAIL if_ready_unexpected got=%h want=no_pulse", bus.if_data);
      end else begin
        exp_v = if_q.pop_front();
        if (bus.if_data !== exp_v) begin bad++; $display("FAIL if_data got=%h want=%h", bus.if_data, exp_v); end
      end
    end
    if (reset && bus.mem_ready) begin
      total++;
      if (mem_q.size() == 0) begin
        bad++; $display("FAIL mem_ready_unexpected got=%h want=no_pulse", bus.mem_rdata);
      end else begin
        exp_v = mem_q.pop_front();
        if (bus.mem_rdata !== exp_v) begin bad++; $display("FAIL mem_rdata got=%h want=%h", bus.mem_rdata, exp_v); end
      end
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (bus.ram_addr !== 32'h0) begin bad++; $display("FAIL rst_ram_addr got=%h want=0", bus.ram_addr); end
    total++; if (bus.ram_wr !== 1'b0) begin bad++; $display("FAIL rst_ram_wr got=%b want=0", bus.ram_wr); end
    total++; if (bus.ram_dout !== 8'h0) begin bad++; $display("FAIL rst_ram_dout got=%h want=0", bus.ram_dout); end
    total++; if (bus.if_ready !== 1'b0 || bus.if_data !== 32'h0) begin bad++; $display("FAIL rst_if got=%b/%h want=0/0", bus.if_ready, bus.if_data); end
    total++; if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL rst_mem got=%b/%h want=0/0", bus.mem_ready, bus.mem_rdata); end
    reset = 1'b1;
    tick();
    total++; if (bus.ram_wr !== 1'b0 || bus.ram_addr !== 32'h0) begin bad++; $display("FAIL post_rst_idle got=%b/%h want=0/0", bus.ram_wr, bus.ram_addr); end
  endtask

  task automatic test_if_fetch();
    poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h10); poke(16'h0103, 8'h00);
    if_q.push_back(32'h00100513);
    bus.if_addr = 32'h100; bus.if_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.ram_addr !== 32'h100 + i || bus.ram_wr !== 1'b0 || if_seen) begin
        bad++; $display("FAIL fetch_addr%0d got=%h/%b/%b want=%h/0/0", i, bus.ram_addr, bus.ram_wr, if_seen, 32'h100 + i);
      end
    end
    tick();
    total++; if (if_seen !== 1'b1) begin bad++; $display("FAIL fetch_ready got=%b want=1", if_seen); end
    bus.if_read = 1'b0;
    tick();
    total++; if (if_seen !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width got=%b want=0", if_seen); end
  endtask

  task automatic test_store_half();
    logic [31:0] ea [2];
    logic [7:0]  ed [2];
    ea[0] = 32'h2000; ea[1] = 32'h2001; ed[0] = 8'hDD; ed[1] = 8'hCC;
    mem_q.push_back(32'h0);
    bus.mem_write = 1'b1; bus.mem_addr = 32'h2000; bus.mem_len = 2'd1; bus.mem_wdata = 32'hAABBCCDD;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.ram_wr !== 1'b1 || bus.ram_addr !== ea[i] || bus.ram_dout !== ed[i] || mem_seen) begin
        bad++; $display("FAIL store_byte%0d got=%b/%h/%h want=1/%h/%h", i, bus.ram_wr, bus.ram_addr, bus.ram_dout, ea[i], ed[i]);
      end
    end
    tick();
    total++; if (bus.ram_wr !== 1'b0 || mem_seen !== 1'b1) begin bad++; $display("FAIL store_done got=%b/%b want=0/1", bus.ram_wr, mem_seen); end
    bus.mem_write = 1'b0;
    tick();
    total++; if (ram[16'h2000] !== 8'hDD || ram[16'h2001] !== 8'hCC) begin bad++; $display("FAIL store_ram got=%h%h want=ccdd", ram[16'h2001], ram[16'h2000]); end
    total++; if (bus.ram_addr !== 32'h2001 || bus.ram_wr !== 1'b0) begin bad++; $display("FAIL store_idle_hold got=%h/%b want=2001/0", bus.ram_addr, bus.ram_wr); end
  endtask

  task automatic test_simultaneous();
    int n;
    poke(16'h0040, 8'h80);
    mem_q.push_back(32'h00000080);
    if_q.push_back(32'h00100513);
    bus.if_addr = 32'h100; bus.if_read = 1'b1;
    bus.mem_addr = 32'h40; bus.mem_len = 2'd0; bus.mem_read = 1'b1;
    tick();
    total++; if (bus.ram_addr !== 32'h40) begin bad++; $display("FAIL sim_mem_first got=%h want=40", bus.ram_addr); end
    tick();
    total++; if (mem_seen !== 1'b1 || if_seen !== 1'b0) begin bad++; $display("FAIL sim_mem_ready got=%b/%b want=1/0", mem_seen, if_seen); end
    bus.mem_read = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!if_seen && n < 12);
    total++; if (n != 6 || !if_seen) begin bad++; $display("FAIL sim_if_latency got=%0d want=6", n); end
    bus.if_read = 1'b0;
    tick();
  endtask

  task automatic test_cancel();
    int n;
    for (int i = 0; i < 4; i++) poke(16'h0300 + 16'(i), 8'hEE);
    poke(16'h0200, 8'h93); poke(16'h0201, 8'h00); poke(16'h0202, 8'h00); poke(16'h0203, 8'h00);
    bus.if_addr = 32'h300; bus.if_read = 1'b1;
    tick(); tick();
    bus.if_cancel = 1'b1; bus.if_read = 1'b0;
    tick();
    bus.if_cancel = 1'b0;
    total++; if (bus.ram_addr !== 32'h301) begin bad++; $display("FAIL cancel_addr_hold got=%h want=301", bus.ram_addr); end
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (if_seen || bus.ram_addr !== 32'h301) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL cancel_no_ready got=%0d want=0", n); end
    total++; if (bus.if_data !== 32'h00100513) begin bad++; $display("FAIL cancel_data_hold got=%h want=00100513", bus.if_data); end
    bus.if_addr = 32'h200; bus.if_read = 1'b1; bus.if_cancel = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (if_seen || bus.ram_addr !== 32'h301) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL cancel_blocks_grant got=%0d want=0", n); end
    bus.if_cancel = 1'b0;
    if_q.push_back(32'h00000093);
    n = 0;
    do begin tick(); n++; end while (!if_seen && n < 12);
    total++; if (!if_seen) begin bad++; $display("FAIL refetch_timeout got=%0d want=ready", n); end
    bus.if_read = 1'b0;
    tick();
  endtask

  task automatic test_load3();
    poke(16'h2002, 8'h77); poke(16'h2003, 8'h99);
    mem_q.push_back(32'h0077CCDD);
    bus.mem_addr = 32'h2000; bus.mem_len = 2'd2; bus.mem_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.ram_addr !== 32'h2000 + i) begin bad++; $display("FAIL load3_addr%0d got=%h want=%h", i, bus.ram_addr, 32'h2000 + i); end
    end
    tick();
    total++; if (mem_seen !== 1'b1) begin bad++; $display("FAIL load3_ready got=%b want=1", mem_seen); end
    bus.mem_read = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] wa [4];
    wa[0] = 32'hFFFFFFFE; wa[1] = 32'hFFFFFFFF; wa[2] = 32'h0; wa[3] = 32'h1;
    poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);
    mem_q.push_back(32'h44332211);
    bus.mem_addr = 32'hFFFFFFFE; bus.mem_len = 2'd3; bus.mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.ram_addr !== wa[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, bus.ram_addr, wa[i]); end
    end
    tick();
    total++; if (mem_seen !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%b want=1", mem_seen); end
    bus.mem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    poke(16'h3002, 8'h5A);
    bus.mem_write = 1'b1; bus.mem_addr = 32'h3000; bus.mem_len = 2'd3; bus.mem_wdata = 32'h01020304;
    tick(); tick();
    total++; if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 32'h3001) begin bad++; $display("FAIL mid_store_pre got=%b/%h want=1/3001", bus.ram_wr, bus.ram_addr); end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.ram_wr !== 1'b0) begin bad++; $display("FAIL async_drop_wr got=%b want=0", bus.ram_wr); end
    bus.mem_write = 1'b0;
    tick(); tick();
    total++; if (mem_seen !== 1'b0) begin bad++; $display("FAIL mid_store_no_ready got=%b want=0", mem_seen); end
    reset = 1'b1;
    tick(); tick();
    total++;
    if (bus.ram_wr !== 1'b0 || bus.ram_addr !== 32'h0 || bus.ram_dout !== 8'h0 || bus.if_ready !== 1'b0 ||
        bus.if_data !== 32'h0 || bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      bad++; $display("FAIL post_mid_reset got=%b/%h/%h/%h/%h want=0/0/0/0/0", bus.ram_wr, bus.ram_addr, bus.ram_dout, bus.if_data, bus.mem_rdata);
    end
    total++; if (ram[16'h3000] !== 8'h04 || ram[16'h3002] !== 8'h5A) begin bad++; $display("FAIL mid_store_ram got=%h/%h want=04/5a", ram[16'h3000], ram[16'h3002]); end
  endtask

  initial begin
    reset = 1'b1;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    bus.if_read = 1'b0; bus.if_addr = '0; bus.if_cancel = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_len = '0; bus.mem_wdata = '0;
    #1 reset = 1'b0;
    test_reset();
    test_if_fetch();
    test_store_half();
    test_simultaneous();
    test_cancel();
    test_load3();
    test_wrap();
    test_reset_mid_store();
    total++;
    if (if_q.size() != 0 || mem_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d/%0d want=0/0", if_q.size(), mem_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
